// File: rtl/lab5_ram_param.sv
// rtl/lab5_ram_param.sv - parametrised single-port RAM with zero-fill init sweep
// Registered read port with valid flag, selectable read-during-write data, busy/reject reporting.
module lab5_ram_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] In,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  ChipSelect,
  input  logic                  Write,
  output logic [DATA_WIDTH-1:0] Out,
  output logic                  OutValid,
  output logic                  Busy,
  output logic                  Rejected
);
  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_rejected;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_init;
  logic                  w_access;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_din;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_init     = (r_state == INIT);
  assign w_access   = !w_init && ChipSelect;
  // rst_n gates the enable so a write on the edge where reset asserts is dropped
  assign w_mem_we   = rst_n && (w_init || (w_access && Write));
  assign w_mem_addr = w_init ? r_cnt : Address;
  assign w_mem_din  = w_init ? '0 : In;
  assign w_rd_data  = r_mem[Address];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b1;
      r_rejected  <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt       <= r_cnt + 1'b1;
          r_out_valid <= 1'b0;
          r_rejected  <= ChipSelect;
          if (r_cnt == LAST_ADDR) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_rejected  <= 1'b0;
          r_out_valid <= w_access;
          if (w_access) begin
            r_out <= (Write && (RDW_MODE != 0)) ? In : w_rd_data;
          end
        end
      endcase
    end
  end

  assign Out      = r_out;
  assign OutValid = r_out_valid;
  assign Busy     = r_busy;
  assign Rejected = r_rejected;

endmodule

// File: tb/tb_lab5_ram_param.sv
// tb/tb_lab5_ram_param.sv - scoreboard bench for lab5_ram_param
// Three instances: 8x64 old-data, 8x64 write-through, 16x16 old-data.
module tb_lab5_ram_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cs = 1'b0, wr = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] out0, out1;
  logic       ov0, ov1, busy0, busy1, rej0, rej1;

  logic        cs2 = 1'b0, wr2 = 1'b0;
  logic [3:0]  addr2 = '0;
  logic [15:0] din2 = '0;
  logic [15:0] out2;
  logic        ov2, busy2, rej2;

  lab5_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .In(din), .Address(addr), .ChipSelect(cs), .Write(wr),
    .Out(out0), .OutValid(ov0), .Busy(busy0), .Rejected(rej0));
  lab5_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .In(din), .Address(addr), .ChipSelect(cs), .Write(wr),
    .Out(out1), .OutValid(ov1), .Busy(busy1), .Rejected(rej1));
  lab5_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .In(din2), .Address(addr2), .ChipSelect(cs2), .Write(wr2),
    .Out(out2), .OutValid(ov2), .Busy(busy2), .Rejected(rej2));

  int n_pass = 0;
  int n_total = 0;
  logic [7:0]  q0[$], q1[$];
  logic [15:0] q2[$];
  logic [7:0]  mdl [64];
  logic [15:0] mdl2 [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (ov0) begin
      if (q0.size() == 0) chk("u0_unexpected_valid", 1, 0);
      else chk("u0_out", {24'd0, out0}, {24'd0, q0.pop_front()});
    end
    if (ov1) begin
      if (q1.size() == 0) chk("u1_unexpected_valid", 1, 0);
      else chk("u1_out", {24'd0, out1}, {24'd0, q1.pop_front()});
    end
    if (ov2) begin
      if (q2.size() == 0) chk("u2_unexpected_valid", 1, 0);
      else chk("u2_out", {16'd0, out2}, {16'd0, q2.pop_front()});
    end
  end

  task automatic acc(input logic w, input int a, input logic [7:0] d);
    q0.push_back(mdl[a]);
    q1.push_back(w ? d : mdl[a]);
    if (w) mdl[a] = d;
    cs = 1'b1; wr = w; addr = a[5:0]; din = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic acc2(input logic w, input int a, input logic [15:0] d);
    q2.push_back(mdl2[a]);
    if (w) mdl2[a] = d;
    cs2 = 1'b1; wr2 = w; addr2 = a[3:0]; din2 = d;
    @(posedge clk); #1;
    cs2 = 1'b0; wr2 = 1'b0;
  endtask

  task automatic count_busy(input int first_edge, output int n0, output int n1, output int n2, output logic quiet);
    n0 = 0; n1 = 0; n2 = 0; quiet = 1'b1;
    for (int e = first_edge; e <= 150; e++) begin
      @(posedge clk); #1;
      if (n0 == 0 && !busy0) n0 = e;
      if (n1 == 0 && !busy1) n1 = e;
      if (n2 == 0 && !busy2) n2 = e;
      if (ov0 || ov1 || ov2 || rej0 || rej1 || rej2 || out0 != 8'h00 || out1 != 8'h00 || out2 != 16'h0)
        quiet = 1'b0;
      if (n0 != 0 && n1 != 0 && n2 != 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, n2;
    logic quiet;
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 16; i++) mdl2[i] = 16'h0000;

    #12;
    chk("rst_out", {24'd0, out0}, 32'h0);
    chk("rst_outvalid", {31'd0, ov0}, 32'h0);
    chk("rst_busy", {29'd0, busy0, busy1, busy2}, 32'h7);
    chk("rst_rejected", {31'd0, rej0}, 32'h0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(1, n0, n1, n2, quiet);
    chk("busy_edges_u0", n0, 64);
    chk("busy_edges_u1", n1, 64);
    chk("busy_edges_u2", n2, 16);
    chk("init_quiet", {31'd0, quiet}, 32'h1);

    acc(0, 0, 8'h00); acc(0, 31, 8'h00); acc(0, 63, 8'h00);
    acc2(1, 15, 16'hBEEF); acc2(0, 15, 16'h0); acc2(0, 0, 16'h0);

    acc(1, 1, 8'h01); acc(1, 2, 8'h02); acc(1, 3, 8'h03);
    for (int i = 1; i <= 3; i++) begin
      acc(0, i, 8'h00);
      chk("b2b_outvalid", {31'd0, ov0}, 32'h1);
    end
    @(posedge clk); #1;
    chk("deselect_outvalid", {30'd0, ov0, ov1}, 32'h0);
    chk("deselect_hold_u0", {24'd0, out0}, 32'h03);
    chk("deselect_hold_u1", {24'd0, out1}, 32'h03);

    acc(1, 4, 8'hAA); acc(1, 4, 8'h55); acc(0, 4, 8'h00);
    for (int i = 0; i < 64; i++) acc(1, i, 8'hFF);

    acc(1, 10, 8'h11);
    cs = 1'b1; wr = 1'b1; addr = 6'd1; din = 8'h99;
    #5;
    rst_n = 1'b0;
    #1;
    chk("midreset_out", {16'd0, out0, out1}, 32'h0);
    chk("midreset_busy", {29'd0, busy0, busy1, busy2}, 32'h7);
    chk("midreset_outvalid", {29'd0, ov0, ov1, ov2}, 32'h0);
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 16; i++) mdl2[i] = 16'h0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cs = 1'b1; wr = 1'b1; addr = 6'd5; din = 8'h77;
    @(posedge clk); #1;
    chk("reject_pulse", {30'd0, rej0, rej1}, 32'h3);
    chk("reject_outvalid", {30'd0, ov0, ov1}, 32'h0);
    cs = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk("reject_clear", {30'd0, rej0, rej1}, 32'h0);
    count_busy(3, n0, n1, n2, quiet);
    chk("resweep_edges_u0", n0, 64);
    chk("resweep_edges_u2", n2, 16);

    acc(0, 0, 8'h00); acc(0, 31, 8'h00); acc(0, 63, 8'h00);
    acc(0, 5, 8'h00); acc(0, 1, 8'h00);
    acc2(0, 15, 16'h0); acc2(1, 15, 16'hBEEF); acc2(0, 15, 16'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lab5_ram_param.md
Name: lab5_ram_param

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 8x64 lab RAM.
- Adds configurable width and depth, registered output with a valid flag, and selectable read-during-write mode.
- Adds a post-reset init sequencer that zero-fills the array and reports Busy, and reports requests rejected while busy.
- Sits behind the datapath/controller as its general-purpose data store.

Parameters:
DATA_WIDTH, 8, bits per word
ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH words
RDW_MODE, 0, read-during-write data on Out: 0 = old contents, 1 = new (write-through)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
In  input  DATA_WIDTH  write data
Address  input  ADDR_WIDTH  word address
ChipSelect  input  1  access request, sampled each rising edge
Write  input  1  1 = write, 0 = read; ignored when ChipSelect=0
Out  output  DATA_WIDTH  registered read data
OutValid  output  1  Out updated by an accepted access on the previous edge
Busy  output  1  init sweep in progress; accesses not accepted
Rejected  output  1  one-cycle pulse: ChipSelect=1 sampled while Busy=1

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n=0, independent of clk.
- Reset values: Out=0, OutValid=0, Busy=1, Rejected=0, init counter=0, state=INIT. The array itself is not reset; the INIT sweep clears it.
- FSM states: INIT, READY.
- INIT, each edge: mem[cnt] <= 0 and cnt <= cnt+1.
  - On the edge that writes cnt = DEPTH-1: state <= READY, Busy <= 0.
  - Busy is therefore high for exactly DEPTH rising edges after rst_n release.
  - In INIT, ChipSelect never writes the array and never changes Out. OutValid stays 0. Rejected <= ChipSelect, regardless of Write.
- READY, each edge:
  - ChipSelect=1, Write=1: mem[Address] <= In. Out <= old mem[Address] if RDW_MODE=0, else In. OutValid <= 1.
  - ChipSelect=1, Write=0: Out <= mem[Address]; OutValid <= 1.
  - ChipSelect=0: Out holds its last value; OutValid <= 0.
  - Rejected <= 0.
- Latency: one clock, request edge to Out/OutValid. Back-to-back accesses are accepted every cycle, with no bubbles.
- Read-after-write to the same address on the next cycle returns the new data in both modes.
- Address covers the full range 0..DEPTH-1; there is no out-of-range case and no wrap logic.
- Reset mid-operation (INIT or READY):
  - Outputs return to reset values at once.
  - The sweep restarts at address 0; all prior contents are lost once the sweep completes.
  - A write in the edge coincident with rst_n assertion is discarded.
- A partial sweep aborted by reset does not shorten the next sweep; the next sweep is always DEPTH edges.
- Init counter is ADDR_WIDTH bits. Its terminal-count compare uses cnt == DEPTH-1 and must not rely on overflow.

Test Plan:
- Reset/init: defaults, release rst_n, hold ChipSelect=0 -> Busy=1 for 64 edges, then 0; Out=0, OutValid=0, Rejected=0 throughout.
- Zero-fill: after init, read addresses 0, 31, 63 -> Out=8'h00 with OutValid=1 one edge after each request. Repeat with the array pre-written to 8'hFF before a second reset -> still 8'h00.
- Write/readback: write 8'h01@1, 8'h02@2, 8'h03@3 on consecutive edges, then read 1,2,3 back-to-back -> Out=01,02,03 on consecutive cycles, OutValid continuously 1. Deselect -> OutValid=0, Out holds 03.
- RDW mode: mem[4]=8'hAA, write 8'h55@4. RDW_MODE=0 -> Out=AA; RDW_MODE=1 -> Out=55. A following read@4 -> 55 in both modes.
- Busy rejection: ChipSelect=1, Write=1, In=8'h77, Address=5 during INIT -> Rejected=1 that cycle, OutValid=0. After init, read@5 -> 8'h00.
- Mid-op reset and parameters: pulse rst_n low between clock edges during a write stream -> Out=0 immediately, Busy=1, re-sweep of 64 edges, read@1 -> 00. Rerun with DATA_WIDTH=16, ADDR_WIDTH=4 -> Busy for 16 edges; write 16'hBEEF@15 reads back 16'hBEEF.
